// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared regfile constants: geometry, the FP bank base and writeback requester indices.
package regfile_pkg;
  localparam int RF_AW      = 6;
  localparam int RF_DW      = 64;
  localparam int RF_NREGS   = 64;
  localparam int RF_FP_BASE = 32;
  localparam int RF_NREQ    = 3;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_FP   = 2;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: requester valid/ready/addr/data, issue-side scoreboard port, and the
// regfile write port. The master side is the execution units/issue logic, the slave is the arbiter.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NREQ  = RF_NREQ,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW,
  parameter int NREGS = RF_NREGS
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic                    issue_valid;
  logic [AW-1:0]           issue_addr;
  logic [NREGS-1:0]        busy_vec;
  logic                    rf_write_enable;
  logic [AW-1:0]           rf_write_addr;
  logic [DW-1:0]           rf_write_data;

  modport master (
    output req_valid, req_addr, req_data, issue_valid, issue_addr,
    input  req_ready, busy_vec, rf_write_enable, rf_write_addr, rf_write_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, issue_valid, issue_addr,
    output req_ready, busy_vec, rf_write_enable, rf_write_addr, rf_write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// rr_pick: one-of-NREQ grant picker.
// RF_WB_RR_EN defined: round-robin, search starts after i_last and wraps.
// RF_WB_RR_EN undefined: fixed priority, lowest index wins (no pointer input).
module rr_pick #(
  parameter int NREQ = 3,
  parameter int LGW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
`ifdef RF_WB_RR_EN
  input  logic [LGW-1:0]  i_last,
`endif
  output logic [NREQ-1:0] o_gnt,
  output logic [LGW-1:0]  o_idx
);
  // Walk the candidates farthest-first so the nearest valid one is written last and wins.
  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
`ifdef RF_WB_RR_EN
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(i_last) + k) % NREQ;
      if (i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = LGW'(j);
      end
    end
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = k;
      if (i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = LGW'(j);
      end
    end
`endif
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single regfile write port among writeback sources,
// registers the winner onto the write port and tracks in-flight destinations.
// Optional macro RF_WB_RR_EN selects round-robin arbitration (default: fixed priority).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = RF_NREQ,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW,
  parameter int NREGS = RF_NREGS
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int LGW = $clog2(NREQ);

  logic [NREQ-1:0]  w_gnt_oh;
  logic [LGW-1:0]   w_gnt_idx;
  logic             w_xfer;
  logic [NREGS-1:0] w_busy_nxt;

  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_data;
  logic [NREGS-1:0] r_busy;

`ifdef RF_WB_RR_EN
  logic [LGW-1:0] r_last;

  rr_pick #(.NREQ(NREQ), .LGW(LGW)) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt_oh),
    .o_idx  (w_gnt_idx)
  );

  // Round-robin pointer: reset so requester 0 is searched first, moves only on a transfer.
  always_ff @(posedge clk) begin
    if (rst)         r_last <= LGW'(NREQ - 1);
    else if (w_xfer) r_last <= w_gnt_idx;
  end
`else
  rr_pick #(.NREQ(NREQ), .LGW(LGW)) u_pick (
    .i_req  (bus.req_valid),
    .o_gnt  (w_gnt_oh),
    .o_idx  (w_gnt_idx)
  );
`endif

  // The picker only grants valid requesters, so any grant outside reset is a transfer.
  assign bus.req_ready = rst ? '0 : w_gnt_oh;
  assign w_xfer        = |(bus.req_valid & bus.req_ready);

  // Write-port register; address 0 is consumed without raising the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_xfer && (bus.req_addr[w_gnt_idx] != '0);
      if (w_xfer) begin
        r_addr <= bus.req_addr[w_gnt_idx];
        r_data <= bus.req_data[w_gnt_idx];
      end
    end
  end

  // Scoreboard next state: clear on the write-port cycle, set on issue (set applied last so it wins).
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we)            w_busy_nxt[r_addr]         = 1'b0;
    if (bus.issue_valid) w_busy_nxt[bus.issue_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // A write still sitting in the output stage when reset arrives is dropped immediately.
  assign bus.rf_write_enable = r_we & ~rst;
  assign bus.rf_write_addr   = r_addr;
  assign bus.rf_write_data   = r_data;
  assign bus.busy_vec        = rst ? '0 : r_busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reset-fresh vector table, directed
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;
  localparam int NREQ = RF_NREQ;
  localparam int AW   = RF_AW;
  localparam int DW   = RF_DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(RF_NREGS)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(RF_NREGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
  endtask

  // Leaves the bench just after a rising edge, reset released, in a fresh cycle.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  // Winner by rule: round-robin starts after 'last', fixed priority takes the lowest index.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef RF_WB_RR_EN
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`else
    if (last < 0) return -1;
    for (int j = 0; j < NREQ; j++)
      if (v[j]) return j;
`endif
    return -1;
  endfunction

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] exp_ready;
    logic [AW-1:0]   exp_addr;
  } vec_t;

  vec_t tbl[7];

  // Random-phase model state.
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic [63:0]     m_busy;
  int              m_last;
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] exp_rdy;

  initial begin
    // Fresh after reset: requester i presents addr 10+i; first winner is the lowest valid index.
    tbl[0] = '{3'b001, 3'b001, 6'd10};
    tbl[1] = '{3'b110, 3'b010, 6'd11};
    tbl[2] = '{3'b100, 3'b100, 6'd12};
    tbl[3] = '{3'b111, 3'b001, 6'd10};
    tbl[4] = '{3'b000, 3'b000, 6'd0};
    tbl[5] = '{3'b101, 3'b001, 6'd10};
    tbl[6] = '{3'b011, 3'b001, 6'd10};

    // ---- reset state and single write ----
    do_reset();
    @(negedge clk);
    check("rst_we",    {63'd0, bus.rf_write_enable}, 64'd0);
    check("rst_waddr", {58'd0, bus.rf_write_addr}, 64'd0);
    check("rst_wdata", bus.rf_write_data, 64'd0);
    check("rst_busy",  bus.busy_vec, 64'd0);
    rst = 1'b1;
    bus.req_valid = 3'b111;
    #1;
    check("ready_in_rst", {61'd0, bus.req_ready}, 64'd0);
    do_reset();
    bus.req_valid = 3'b001; bus.req_addr[0] = 6'd5; bus.req_data[0] = 64'hAA;
    @(negedge clk);
    check("single_ready", {61'd0, bus.req_ready}, 64'd1);
    nxt();
    bus.req_valid = '0;
    @(negedge clk);
    check("single_we",    {63'd0, bus.rf_write_enable}, 64'd1);
    check("single_waddr", {58'd0, bus.rf_write_addr}, 64'd5);
    check("single_wdata", bus.rf_write_data, 64'hAA);
    nxt();
    @(negedge clk);
    check("single_we_off", {63'd0, bus.rf_write_enable}, 64'd0);

    // ---- vector table ----
    foreach (tbl[t]) begin
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
        bus.req_addr[i] = AW'(10 + i);
        bus.req_data[i] = 64'h100 + 64'(i);
      end
      bus.req_valid = tbl[t].valid;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", t), {61'd0, bus.req_ready}, {61'd0, tbl[t].exp_ready});
      nxt();
      bus.req_valid = '0;
      @(negedge clk);
      check($sformatf("tbl%0d_we", t), {63'd0, bus.rf_write_enable}, {63'd0, |tbl[t].valid});
      if (tbl[t].valid != '0)
        check($sformatf("tbl%0d_waddr", t), {58'd0, bus.rf_write_addr}, {58'd0, tbl[t].exp_addr});
    end

    // ---- contention: all three held for six cycles ----
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i] = AW'(20 + i);
      bus.req_data[i] = 64'h200 + 64'(i);
    end
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
`ifdef RF_WB_RR_EN
      check($sformatf("cont%0d_ready", c), {61'd0, bus.req_ready}, 64'd1 << (c % 3));
`else
      check($sformatf("cont%0d_ready", c), {61'd0, bus.req_ready}, 64'd1);
`endif
      if (c > 0) begin
`ifdef RF_WB_RR_EN
        check($sformatf("cont%0d_waddr", c), {58'd0, bus.rf_write_addr}, 64'(20 + (c - 1) % 3));
`else
        check($sformatf("cont%0d_waddr", c), {58'd0, bus.rf_write_addr}, 64'd20);
`endif
      end
      nxt();
    end
    bus.req_valid = '0;

    // ---- address zero ----
    do_reset();
    bus.req_valid = 3'b001; bus.req_addr[0] = '0; bus.req_data[0] = 64'hFF;
    bus.issue_valid = 1'b1; bus.issue_addr = '0;
    @(negedge clk);
    check("a0_ready", {61'd0, bus.req_ready}, 64'd1);
    nxt();
    bus.req_valid = '0; bus.issue_valid = 1'b0;
    @(negedge clk);
    check("a0_we",    {63'd0, bus.rf_write_enable}, 64'd0);
    check("a0_busy0", {63'd0, bus.busy_vec[0]}, 64'd0);

    // ---- scoreboard ----
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_addr = 6'd40;
    nxt();
    bus.issue_valid = 1'b0;
    bus.req_valid = 3'b010; bus.req_addr[1] = 6'd40; bus.req_data[1] = 64'h1234;
    @(negedge clk);
    check("sb_set",   {63'd0, bus.busy_vec[40]}, 64'd1);
    check("sb_ready", {61'd0, bus.req_ready}, 64'd2);
    nxt();
    bus.req_valid = '0;
    @(negedge clk);
    check("sb_we",    {63'd0, bus.rf_write_enable}, 64'd1);
    check("sb_hold",  {63'd0, bus.busy_vec[40]}, 64'd1);
    nxt();
    @(negedge clk);
    check("sb_clear", {63'd0, bus.busy_vec[40]}, 64'd0);
    // Re-issue during the write cycle: set wins.
    bus.issue_valid = 1'b1; bus.issue_addr = 6'd40;
    nxt();
    bus.issue_valid = 1'b0;
    bus.req_valid = 3'b010;
    @(negedge clk);
    check("sb2_ready", {61'd0, bus.req_ready}, 64'd2);
    nxt();
    bus.req_valid = '0;
    bus.issue_valid = 1'b1; bus.issue_addr = 6'd40;
    nxt();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("sb_waw_keep", {63'd0, bus.busy_vec[40]}, 64'd1);

    // ---- reset mid-flight ----
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_addr = 6'd12;
    nxt();
    bus.issue_valid = 1'b0;
    bus.req_valid = 3'b100; bus.req_addr[2] = 6'd33; bus.req_data[2] = 64'h55;
    @(negedge clk);
    check("mf_ready", {61'd0, bus.req_ready}, 64'd4);
    nxt();
    rst = 1'b1; bus.req_valid = 3'b111;
    @(negedge clk);
    check("mf_we",    {63'd0, bus.rf_write_enable}, 64'd0);
    check("mf_busy",  bus.busy_vec, 64'd0);
    check("mf_ready_rst", {61'd0, bus.req_ready}, 64'd0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check("mf_after_ready", {61'd0, bus.req_ready}, 64'd1);
    check("mf_after_we",    {63'd0, bus.rf_write_enable}, 64'd0);

    // ---- randomized traffic against model ----
    do_reset();
    m_we = 1'b0; m_addr = '0; m_data = '0; m_busy = '0; m_last = NREQ - 1; pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int w;
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          bus.req_addr[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          bus.req_data[i] = {$urandom, $urandom};
        end
      end
      bus.req_valid   = pend;
      bus.issue_valid = ($urandom_range(0, 1) == 0);
      bus.issue_addr  = AW'($urandom);
      w = rst ? -1 : pick(pend, m_last);
      exp_rdy = (w < 0) ? '0 : NREQ'(1 << w);
      @(negedge clk);
      check("rnd_ready", {61'd0, bus.req_ready}, {61'd0, exp_rdy});
      check("rnd_we",    {63'd0, bus.rf_write_enable}, {63'd0, m_we & ~rst});
      check("rnd_waddr", {58'd0, bus.rf_write_addr}, {58'd0, m_addr});
      check("rnd_wdata", bus.rf_write_data, m_data);
      check("rnd_busy",  bus.busy_vec, rst ? 64'd0 : m_busy);
      @(posedge clk);
      if (rst) begin
        m_we = 1'b0; m_addr = '0; m_data = '0; m_busy = '0; m_last = NREQ - 1; pend = '0;
      end else begin
        if (m_we) m_busy[m_addr] = 1'b0;
        if (bus.issue_valid) m_busy[bus.issue_addr] = 1'b1;
        m_busy[0] = 1'b0;
        m_we = 1'b0;
        if (w >= 0) begin
          m_we   = (bus.req_addr[w] != 0);
          m_addr = bus.req_addr[w];
          m_data = bus.req_data[w];
          m_last = w;
          pend[w] = 1'b0;
        end
      end
      #1;
    end
    rst = 1'b0;
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 64-entry register file (x0–x31 at addresses 0–31, f0–f31 at addresses 32–63) among several writeback sources, such as the integer ALU, the load unit and the FP unit. It arbitrates valid/ready requests, registers the winner onto the regfile write port, and keeps a pending-write scoreboard so issue logic can stall on registers whose result is still in flight. It sits between the execution units and the regfile.

## Interface
- NREQ, 3, number of writeback requesters; index 0 is the ALU, 1 is load, 2 is FP.
- AW, 6, regfile address width.
- DW, 64, regfile data width.
- NREGS, 64, number of scoreboard entries (2**AW).

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  requester i holds a pending write.
- req_ready  output  NREQ  requester i's write is accepted this cycle.
- req_addr  input  NREQ*AW  write address; slice i is requester i.
- req_data  input  NREQ*DW  write data; slice i is requester i.
- issue_valid  input  1  an instruction with a destination register issues this cycle.
- issue_addr  input  AW  destination register of the issuing instruction.
- busy_vec  output  NREGS  bit r=1 means a write to r is pending.
- rf_write_enable  output  1  regfile write enable (registered).
- rf_write_addr  output  AW  regfile write address (registered).
- rf_write_data  output  DW  regfile write data (registered).

## Operation
- Accept: at most one requester per cycle.
  - req_ready[i]=1 only for the arbitration winner, and only when req_valid[i]=1.
  - Transfer occurs when req_valid[i] & req_ready[i].
  - Ready is combinational from req_valid and the arbiter state.
- Requesters hold addr/data stable while valid and not ready. A requester must not drop valid before it is accepted.
- Output stage: on a transfer, the next edge loads rf_write_enable=1, rf_write_addr=req_addr[i] and rf_write_data=req_data[i]. With no transfer, rf_write_enable=0 and addr/data hold their previous values.
- Address 0: the request is accepted normally and consumed. rf_write_enable stays 0 for that cycle.
- Scoreboard, per bit r:
  - Set on issue_valid with issue_addr=r (r≠0).
  - Cleared on the edge after rf_write_enable=1 with rf_write_addr=r.
  - If set and clear hit the same r in the same cycle, set wins (a new producer has issued).
  - Bit 0 is always 0.
  - Issuing to an already-busy register (WAW) leaves the bit set. The first writeback clears it; ordering is the issue logic's responsibility.
- Arbiter state: last_grant pointer (log2 NREQ bits). It updates only on a transfer, to the granted index.

## Timing
- Reset values:
  - rf_write_enable=0, rf_write_addr=0, rf_write_data=0.
  - busy_vec=0.
  - last_grant=NREQ-1, so requester 0 wins first.
  - req_ready=0 while rst=1.
- Latency:
  - Accept in cycle N drives the regfile write port in cycle N+1. The regfile commits on that cycle's falling edge, so the value is readable in cycle N+2.
  - busy bit clears at the end of N+1, so busy_vec shows 0 from cycle N+2.
- Throughput: one write per cycle with no bubbles under continuous requests.
- Reset asserted mid-operation:
  - An accepted but not-yet-written request is discarded.
  - Scoreboard is cleared.
  - Requesters are expected to be reset in the same cycle.

## Configuration
- RF_WB_RR_EN defined: round-robin. The search starts at last_grant+1 and wraps modulo NREQ. The first valid requester wins. Under continuous requests from all sources, grants rotate 0,1,2,0,…
- RF_WB_RR_EN undefined: fixed priority, lowest index wins. last_grant is not implemented and busy_vec behaviour is unchanged.

## Structure
- Shared package regfile_pkg holds:
  - RF_AW=6, RF_DW=64, RF_NREGS=64, RF_FP_BASE=32.
  - Requester index constants WB_ALU=0, WB_LOAD=1, WB_FP=2.
- One sub-module, rr_pick:
  - Inputs: NREQ-bit request vector and last_grant.
  - Outputs: one-hot grant and its encoded index.
  - Fixed-priority mode when RF_WB_RR_EN is undefined.

## Test plan
- Reset, then single write. req_valid=001, addr=5, data=0xAA in cycle 1 → req_ready=001 in cycle 1. Cycle 2: rf_write_enable=1, addr=5, data=0xAA. Cycle 3: rf_write_enable=0.
- Contention. req_valid=111 held for 6 cycles with RF_WB_RR_EN → grants 0,1,2,0,1,2. Without the macro → grant 0 every cycle, while 1 and 2 see req_ready=0.
- Address zero. Accept a request with addr=0, data=0xFF → req_ready=1, then rf_write_enable=0. busy_vec[0] stays 0.
- Scoreboard. issue_valid with issue_addr=40 → busy_vec[40]=1 next cycle. A writeback to 40 accepted in cycle N → busy_vec[40]=0 from cycle N+2. Re-issue 40 in cycle N+1 (the write cycle) → busy_vec[40] stays 1.
- Reset mid-flight. Accept a request in cycle N and assert rst in cycle N+1 → rf_write_enable=0 in N+1 and busy_vec=0. After reset, the next grant goes to requester 0.
